// File: rtl/gray_counter_param.sv
// gray_counter_param
//   Parametrised up/down Gray-code counter with count enable, direction
//   control, synchronous parallel load, wrap or saturate at the terminal
//   value, a registered terminal-count pulse and a registered binary
//   companion output. Suited to async-FIFO pointers and encoder sequences
//   where the published value must change one bit at a time.
//
// Parameters
//   WIDTH     counter width in bits (2..32)
//   WRAP      1 = wrap at the terminal value, 0 = saturate (hold) there
//   RESET_VAL binary value loaded on reset
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active high
//   en       in   count enable
//   up       in   1 = increment, 0 = decrement
//   load     in   synchronous parallel load strobe (beats en)
//   load_val in   binary value to load
//   g_count  out  registered Gray-code count
//   b_count  out  registered binary count, always consistent with g_count
//   tc       out  registered terminal-count pulse
module gray_counter_param #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          WRAP      = 1'b1,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] g_count,
    output logic [WIDTH-1:0] b_count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] RST_B = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE_B = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_B = '1;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Modulo-2^WIDTH step; the carry/borrow out is simply dropped.
    function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] b,
                                                  input logic             dir_up);
        return dir_up ? (b + ONE_B) : (b - ONE_B);
    endfunction

    logic             at_term;
    logic             blocked;
    logic [WIDTH-1:0] b_next;

    always_comb begin
        at_term = up ? (b_count == MAX_B) : (b_count == '0);
        // In saturate mode the terminal value is sticky while counting on.
        blocked = at_term && !WRAP;
        b_next  = step_val(b_count, up);
    end

    // Stage boundary: binary and Gray registers are written together from
    // the same next value, so g_count never decodes a stale b_count.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_count <= RST_B;
            g_count <= to_gray(RST_B);
            tc      <= 1'b0;
        end else if (load) begin
            b_count <= load_val;
            g_count <= to_gray(load_val);
            tc      <= 1'b0;
        end else if (en) begin
            if (!blocked) begin
                b_count <= b_next;
                g_count <= to_gray(b_next);
            end
            tc <= at_term;
        end else begin
            tc <= 1'b0;
        end
    end

endmodule
